cordic_angle_sequencer: RTL and testbench

//   Parametrised successor of the fixed 32x32 hyperbolic angle ROM for the CORDIC datapath.

---
 rtl/cordic_angle_sequencer_if.sv | 28 ++
 rtl/cordic_angle_sequencer.sv | 150 +++++++++++++++
 tb/tb_cordic_angle_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_angle_sequencer_if.sv
// Step handshake between the CORDIC angle sequencer (master) and its controller/rotator (slave).
`timescale 1ns/1ps
interface cordic_angle_sequencer_if #(
    parameter int P = 32,
    parameter int D = 5
);
    logic         start;
    logic         mode;
    logic         neg;
    logic         abort;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [P-1:0] angle;
    logic [D-1:0] shift;
    logic         last;
    logic         done;

    modport master (
        input  start, mode, neg, abort, ready,
        output busy, valid, angle, shift, last, done
    );

    modport slave (
        output start, mode, neg, abort, ready,
        input  busy, valid, angle, shift, last, done
    );
endinterface

// File: rtl/cordic_angle_sequencer.sv
// Purpose: emits (shift k, signed atan/atanh(2^-k)) per CORDIC step with the hyperbolic 4/13 repeats.
// Latency: first step valid 2 cycles after START; one step per 2 cycles; DONE 1 cycle after last acceptance.
// Backpressure: step held stable in PRESENT while ready is low; abort cancels without a DONE pulse.
`timescale 1ns/1ps
module cordic_angle_sequencer #(
    parameter int P    = 32,
    parameter int D    = 5,
    parameter int ITER = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    cordic_angle_sequencer_if.master bus
);
    localparam int            SW        = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(ITER - 1);
    localparam logic [D-1:0]  K_MAX     = '1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic          neg_q, neg_d;
    logic          rep_q, rep_d;
    logic [D-1:0]  k_q, k_d;
    logic [SW-1:0] step_q, step_d;
    logic [P-2:0]  rom_q, rom_d;

    // Magnitudes only; beyond k=11 both functions round to exactly 2^-k in single precision.
    function automatic logic [30:0] atan_rom(input logic [D-1:0] k);
        logic [30:0] r;
        case (int'(k))
            0:       r = 31'h3F490FDB;
            1:       r = 31'h3EED6338;
            2:       r = 31'h3E7ADBB0;
            3:       r = 31'h3DFEADD5;
            4:       r = 31'h3D7FAADE;
            5:       r = 31'h3CFFEAAE;
            6:       r = 31'h3C7FFAAB;
            7:       r = 31'h3BFFFEAB;
            8:       r = 31'h3B7FFFAB;
            9:       r = 31'h3AFFFFEB;
            10:      r = 31'h3A7FFFFB;
            11:      r = 31'h39FFFFFF;
            default: r = {8'(127 - int'(k)), 23'd0};
        endcase
        return r;
    endfunction

    function automatic logic [30:0] atanh_rom(input logic [D-1:0] k);
        logic [30:0] r;
        case (int'(k))
            0:       r = 31'h00000000;
            1:       r = 31'h3F0C9F54;
            2:       r = 31'h3E82C578;
            3:       r = 31'h3E00AC49;
            4:       r = 31'h3D802AC4;
            5:       r = 31'h3D000AAC;
            6:       r = 31'h3C8002AB;
            7:       r = 31'h3C0000AB;
            8:       r = 31'h3B80002B;
            9:       r = 31'h3B00000B;
            10:      r = 31'h3A800003;
            11:      r = 31'h3A000001;
            default: r = {8'(127 - int'(k)), 23'd0};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        rep_d   = rep_q;
        k_d     = k_q;
        step_d  = step_q;
        rom_d   = rom_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    mode_d  = bus.mode;
                    neg_d   = bus.neg;
                    k_d     = {{(D-1){1'b0}}, bus.mode};
                    step_d  = '0;
                    rep_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.abort) begin
                    mode_d  = 1'b0;
                    neg_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    rom_d   = (P-1)'(mode_q ? atanh_rom(k_q) : atan_rom(k_q));
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.abort) begin
                    mode_d  = 1'b0;
                    neg_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.ready) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_FETCH;
                        // Hyperbolic convergence needs k=4 and k=13 issued twice back to back.
                        if (mode_q && !rep_q && (int'(k_q) == 4 || int'(k_q) == 13)) begin
                            rep_d = 1'b1;
                        end else begin
                            rep_d = 1'b0;
                            if (k_q != K_MAX) k_d = k_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            rep_q   <= 1'b0;
            k_q     <= '0;
            step_q  <= '0;
            rom_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            rep_q   <= rep_d;
            k_q     <= k_d;
            step_q  <= step_d;
            rom_q   <= rom_d;
        end
    end

    assign bus.busy  = (state_q == S_FETCH) || (state_q == S_PRESENT);
    assign bus.valid = (state_q == S_PRESENT);
    assign bus.done  = (state_q == S_DONE);
    assign bus.last  = (state_q == S_PRESENT) && (step_q == LAST_STEP);
    assign bus.angle = {neg_q, rom_q};
    assign bus.shift = k_q;
endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Bench: three sequencer instances (32 steps, 1 step, 4-entry tables) share one stimulus stream.
`timescale 1ns/1ps
module tb_cordic_angle_sequencer;
    localparam int ITERS [3] = '{32, 1, 4};
    localparam int DS    [3] = '{5, 5, 2};

    logic clk = 1'b0;
    logic rst_n;
    logic start, mode, neg, abort, ready;

    int n_pass = 0;
    int n_total = 0;

    cordic_angle_sequencer_if #(.P(32), .D(5)) if0 ();
    cordic_angle_sequencer_if #(.P(32), .D(5)) if1 ();
    cordic_angle_sequencer_if #(.P(32), .D(2)) if2 ();

    cordic_angle_sequencer #(.P(32), .D(5), .ITER(32)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
    cordic_angle_sequencer #(.P(32), .D(5), .ITER(1))  u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
    cordic_angle_sequencer #(.P(32), .D(2), .ITER(4))  u2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

    assign if0.start = start; assign if0.mode = mode; assign if0.neg = neg;
    assign if0.abort = abort; assign if0.ready = ready;
    assign if1.start = start; assign if1.mode = mode; assign if1.neg = neg;
    assign if1.abort = abort; assign if1.ready = ready;
    assign if2.start = start; assign if2.mode = mode; assign if2.neg = neg;
    assign if2.abort = abort; assign if2.ready = ready;

    logic        busy_o [3], valid_o [3], done_o [3], last_o [3];
    logic [4:0]  shf_o [3];
    logic [31:0] ang_o [3];
    assign busy_o[0] = if0.busy; assign valid_o[0] = if0.valid; assign done_o[0] = if0.done;
    assign last_o[0] = if0.last; assign shf_o[0] = if0.shift; assign ang_o[0] = if0.angle;
    assign busy_o[1] = if1.busy; assign valid_o[1] = if1.valid; assign done_o[1] = if1.done;
    assign last_o[1] = if1.last; assign shf_o[1] = if1.shift; assign ang_o[1] = if1.angle;
    assign busy_o[2] = if2.busy; assign valid_o[2] = if2.valid; assign done_o[2] = if2.done;
    assign last_o[2] = if2.last; assign shf_o[2] = {3'b000, if2.shift}; assign ang_o[2] = if2.angle;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Round a positive real to IEEE-754 single bits (round to nearest).
    function automatic logic [31:0] f32(input real v);
        int  e = 0;
        real m = v;
        int  mant;
        if (v == 0.0) return 32'h0;
        while (m < 1.0) begin m = m * 2.0; e--; end
        while (m >= 2.0) begin m = m / 2.0; e++; end
        mant = $rtoi(m * 8388608.0 + 0.5);
        if (mant >= 16777216) begin mant = mant / 2; e++; end
        return {1'b0, 8'(e + 127), 23'(mant)};
    endfunction

    // Shift amount of step i: circular counts up, hyperbolic starts at 1 and repeats 4 and 13.
    function automatic int kexp(input bit m, input int d, input int i);
        int k;
        int kmax = (1 << d) - 1;
        if (!m)         k = i;
        else if (i < 4) k = i + 1;
        else if (i < 14) k = i;
        else            k = i - 1;
        return (k > kmax) ? kmax : k;
    endfunction

    function automatic logic [31:0] exp_angle(input bit m, input bit n, input int k);
        real x = 1.0;
        logic [31:0] b;
        for (int j = 0; j < k; j++) x = x / 2.0;
        b = f32(m ? $atanh(x) : $atan(x));
        b[31] = n;
        return b;
    endfunction

    // Run model: 0 idle, 1 gap before a step, 2 step presented, 3 done pulse.
    int ph [3] = '{0, 0, 0};
    int idx [3] = '{0, 0, 0};
    bit mm [3], nn [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) ph[i] = 0;
            else case (ph[i])
                0: if (start && !abort) begin mm[i] = mode; nn[i] = neg; idx[i] = 0; ph[i] = 1; end
                1: ph[i] = abort ? 0 : 2;
                2: if (abort) ph[i] = 0;
                   else if (ready) begin
                       if (idx[i] == ITERS[i] - 1) ph[i] = 3;
                       else begin idx[i]++; ph[i] = 1; end
                   end
                default: ph[i] = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk($sformatf("u%0d_rst_busy", i), busy_o[i], 0);
                chk($sformatf("u%0d_rst_valid", i), valid_o[i], 0);
                chk($sformatf("u%0d_rst_done", i), done_o[i], 0);
                chk($sformatf("u%0d_rst_angle", i), ang_o[i], 0);
                chk($sformatf("u%0d_rst_shift", i), shf_o[i], 0);
            end else begin
                chk($sformatf("u%0d_busy", i), busy_o[i], (ph[i] == 1 || ph[i] == 2));
                chk($sformatf("u%0d_valid", i), valid_o[i], (ph[i] == 2));
                chk($sformatf("u%0d_done", i), done_o[i], (ph[i] == 3));
                if (ph[i] == 2) begin
                    chk($sformatf("u%0d_shift_s%0d", i, idx[i]), shf_o[i], kexp(mm[i], DS[i], idx[i]));
                    chk($sformatf("u%0d_angle_s%0d", i, idx[i]), ang_o[i],
                        exp_angle(mm[i], nn[i], kexp(mm[i], DS[i], idx[i])));
                    chk($sformatf("u%0d_last_s%0d", i, idx[i]), last_o[i], (idx[i] == ITERS[i] - 1));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input bit m, input bit n);
        start = 1'b1; mode = m; neg = n;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((if0.busy || if0.done) && n < 300) begin tick(1); n++; end
        chk(name, (n < 300), 1);
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, last_cyc, dones;
        int sh_q [$];
        logic [31:0] an_q [$];
        logic [31:0] an0;
        logic [4:0]  sh0;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; neg = 1'b0; abort = 1'b0; ready = 1'b1;
        tick(3);
        chk("reset_angle", if0.angle, 0);
        chk("reset_shift", if0.shift, 0);
        chk("reset_busy", if0.busy, 0);
        rst_n = 1'b1;
        tick(2);

        // Circular, positive, ready high: literal ROM pins and DONE/LAST timing.
        go(0, 0);
        tick(1);
        chk("circ_s0_angle", if0.angle, 32'h3F490FDB);
        chk("circ_s0_shift", if0.shift, 0);
        tick(2);
        chk("circ_s1_angle", if0.angle, 32'h3EED6338);
        cyc = 4; last_cyc = -1;
        while (!if0.done && cyc < 200) begin
            if (if0.last) last_cyc = cyc;
            tick(1); cyc++;
        end
        chk("circ_done_cycle", cyc, 65);
        chk("circ_last_cycle", last_cyc, 64);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("done_single_cycle", if0.done, 0);
        tick(2);

        // Hyperbolic, negative: repeat schedule, single-step instance.
        go(1, 1);
        tick(1);
        chk("hyp_s0_angle", if0.angle, 32'hBF0C9F54);
        chk("hyp_s0_shift", if0.shift, 1);
        chk("iter1_valid", if1.valid, 1);
        chk("iter1_shift", if1.shift, 1);
        chk("iter1_last", if1.last, 1);
        sh_q.push_back(int'(if0.shift)); an_q.push_back(if0.angle);
        tick(1);
        chk("iter1_done", if1.done, 1);
        cyc = 3; dones = 0;
        while (cyc < 80) begin
            if (if0.valid) begin sh_q.push_back(int'(if0.shift)); an_q.push_back(if0.angle); end
            if (if0.done) dones++;
            tick(1); cyc++;
        end
        chk("hyp_steps", sh_q.size(), 32);
        chk("hyp_s3_shift", sh_q[3], 4);
        chk("hyp_s4_shift", sh_q[4], 4);
        chk("hyp_s5_shift", sh_q[5], 5);
        chk("hyp_s14_shift", sh_q[14], 13);
        chk("hyp_s31_shift", sh_q[31], 30);
        chk("hyp_s3_angle", an_q[3], 32'hBD802AC4);
        chk("hyp_s3_eq_s4", an_q[4], an_q[3]);
        chk("hyp_done_pulses", dones, 1);
        wait_idle("hyp_idle");

        // Backpressure: ready low for 5 cycles at step 2.
        go(0, 1);
        tick(5);
        ready = 1'b0;
        sh0 = if0.shift; an0 = if0.angle;
        chk("stall_shift", sh0, 2);
        chk("stall_angle", an0, 32'hBE7ADBB0);
        tick(4);
        chk("stall_valid_held", if0.valid, 1);
        chk("stall_shift_held", if0.shift, sh0);
        chk("stall_angle_held", if0.angle, an0);
        tick(1);
        ready = 1'b1;
        tick(2);
        chk("stall_next_shift", if0.shift, 3);
        chk("stall_next_valid", if0.valid, 1);
        wait_idle("stall_idle");

        // Abort at step 10 with stray STARTs; then a fresh circular run.
        go(1, 0);
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(16);
        chk("abort_at_shift", if0.shift, 10);
        abort = 1'b1; start = 1'b1;
        tick(1);
        chk("abort_busy", if0.busy, 0);
        chk("abort_valid", if0.valid, 0);
        tick(1);
        abort = 1'b0; start = 1'b0;
        chk("abort_start_ignored", if0.busy, 0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (if0.done) dones++;
            tick(1);
        end
        chk("abort_no_done", dones, 0);
        go(0, 0);
        tick(1);
        chk("fresh_valid", if0.valid, 1);
        chk("fresh_shift", if0.shift, 0);
        wait_idle("fresh_idle");

        // Asynchronous reset in the middle of a presented step.
        go(0, 0);
        tick(1);
        chk("prerst_valid", if0.valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", if0.valid, 0);
        chk("midrst_busy", if0.busy, 0);
        chk("midrst_done", if0.done, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("postrst_busy", if0.busy, 0);
        chk("postrst_valid", if0.valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
